// File: rtl/sect_pt_mul_serial_bridge.sv
// sect_pt_mul_serial_bridge: serial command in, core start/done handshake with timeout, serial status+result out
module sect_pt_mul_serial_bridge #(
  parameter int IN_WIDTH  = 574,
  parameter int OUT_WIDTH = 1143,
  parameter int TIMEOUT   = 0,
  parameter int TMR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_in_valid,
  output logic                 bit_out,
  output logic                 bit_out_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic [IN_WIDTH-1:0]  core_din,
  output logic                 core_start,
  output logic                 core_clr,
  input  logic                 core_done,
  input  logic [OUT_WIDTH-1:0] core_dout
);
  localparam int CW = $clog2(IN_WIDTH);
  localparam int OW = $clog2(OUT_WIDTH + 1);
  typedef enum logic [1:0] {LOAD, FIRE, WAIT, SHIFT} state_t;
  state_t state, next;
  logic [CW-1:0]        cnt;
  logic [OW-1:0]        ocnt;
  logic [TMR_WIDTH-1:0] timer;
  logic [IN_WIDTH-2:0]  shreg_in;
  logic [OUT_WIDTH:0]   out_shreg;
  logic [IN_WIDTH-1:0]  word;
  logic                 last_in, last_out, timeout_hit;
  assign word        = {shreg_in, bit_in};
  assign last_in     = bit_in_valid && cnt == CW'(IN_WIDTH - 1);
  assign last_out    = ocnt == OW'(OUT_WIDTH);
  assign timeout_hit = (TIMEOUT != 0) && timer == TMR_WIDTH'(TIMEOUT - 1);
  assign busy          = state != LOAD;
  assign bit_out_valid = state == SHIFT;
  assign bit_out       = bit_out_valid & out_shreg[OUT_WIDTH];
  always_comb begin
    next       = state;
    core_start = 1'b0;
    core_clr   = 1'b0;
    case (state)
      LOAD:  next = last_in ? FIRE : LOAD;
      FIRE: begin
        next       = WAIT;
        core_start = 1'b1;
      end
      WAIT: begin
        next     = (core_done || timeout_hit) ? SHIFT : WAIT;
        core_clr = !core_done && timeout_hit;
      end
      default: next = last_out ? LOAD : SHIFT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      ocnt      <= '0;
      timer     <= '0;
      shreg_in  <= '0;
      out_shreg <= '0;
      core_din  <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= next;
      if (busy && bit_in_valid) overrun <= 1'b1;
      if (state == LOAD && bit_in_valid) begin
        shreg_in <= word[IN_WIDTH-2:0];
        cnt      <= last_in ? '0 : cnt + 1'b1;
        if (last_in) core_din <= word;
      end
      if (state == FIRE) timer <= '0;
      if (state == WAIT) begin
        ocnt <= '0;
        if (core_done) out_shreg <= {1'b0, core_dout};
        else if (timeout_hit) out_shreg <= {1'b1, {OUT_WIDTH{1'b0}}};
        else timer <= timer + 1'b1;
      end
      if (state == SHIFT) begin
        out_shreg <= out_shreg << 1;
        ocnt      <= ocnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sect_pt_mul_serial_bridge.sv
// tb_sect_pt_mul_serial_bridge: scoreboarded random transactions; second instance checks the disabled timeout
module tb_sect_pt_mul_serial_bridge;
  localparam int IW = 8, OW = 8, TO = 16;
  logic clk = 0, rst = 1, bit_in = 0, bit_in_valid = 0, core_done = 0;
  logic [OW-1:0] core_dout = '0;
  logic bit_out, bit_out_valid, busy, overrun, core_start, core_clr;
  logic [IW-1:0] core_din;
  logic bit_out2, bit_out_valid2, busy2, overrun2, core_start2, core_clr2;
  logic [IW-1:0] core_din2;
  int checks = 0, errors = 0, clr_seen = 0, exp_clr = 0, clr2_seen = 0, v2_seen = 0, nb = 0;
  logic [OW:0] frame;
  logic [IW-1:0] din_q[$];
  logic [OW:0] resp_q[$];

  sect_pt_mul_serial_bridge #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(TO), .TMR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_in_valid(bit_in_valid), .bit_out(bit_out),
    .bit_out_valid(bit_out_valid), .busy(busy), .overrun(overrun), .core_din(core_din),
    .core_start(core_start), .core_clr(core_clr), .core_done(core_done), .core_dout(core_dout));

  sect_pt_mul_serial_bridge #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(0), .TMR_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_in_valid(bit_in_valid), .bit_out(bit_out2),
    .bit_out_valid(bit_out_valid2), .busy(busy2), .overrun(overrun2), .core_din(core_din2),
    .core_start(core_start2), .core_clr(core_clr2), .core_done(1'b0), .core_dout(8'h00));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) nb = 0;
    else begin
      if (core_start) begin
        if (din_q.size() == 0) chk("unexpected_start", 1, 0);
        else chk("core_din_at_start", core_din, din_q.pop_front());
      end
      if (core_clr) clr_seen++;
      if (core_clr2) clr2_seen++;
      if (bit_out_valid2) v2_seen++;
      if (!bit_out_valid && bit_out) chk("bit_out_idle", bit_out, 0);
      if (bit_out_valid) begin
        frame = {frame[OW-1:0], bit_out};
        nb++;
        if (nb == OW + 1) begin
          if (resp_q.size() == 0) chk("unexpected_frame", 1, 0);
          else chk("response_frame", frame, resp_q.pop_front());
          nb = 0;
        end
      end else if (nb != 0) begin
        chk("frame_length", nb, OW + 1);
        nb = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_bit(input logic b);
    bit_in = b;
    bit_in_valid = 1;
    idle(1);
    bit_in_valid = 0;
  endtask

  task automatic send_word(input logic [IW-1:0] w, input int gpos, input int glen);
    for (int i = IW - 1; i >= 0; i--) begin
      put_bit(w[i]);
      if (i == gpos) idle(glen);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      idle(1);
      n++;
    end
    if (busy) chk("return_to_load_bound", busy, 0);
  endtask

  // done pulsed in WAIT cycle k (1-based); the timeout fires in WAIT cycle TO unless done arrives no later
  task automatic xact(input logic [IW-1:0] w, input int k, input logic [OW-1:0] d, input int gpos, input int glen);
    send_word(w, gpos, glen);
    din_q.push_back(w);
    chk("start_latency", core_start, 1);
    chk("busy_with_start", busy, 1);
    if (k <= TO) resp_q.push_back({1'b0, d});
    else begin
      resp_q.push_back({1'b1, {OW{1'b0}}});
      exp_clr++;
    end
    idle(1);
    chk("start_one_cycle", core_start, 0);
    idle(k - 1);
    core_done = 1;
    core_dout = d;
    idle(1);
    core_done = 0;
    if (k <= TO) chk("first_out_valid", bit_out_valid, 1);
    wait_idle();
    chk("core_din_held", core_din, w);
    idle($urandom_range(0, 2));
  endtask

  initial begin
    idle(2);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_bit_out_valid", bit_out_valid, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_start_clr", {core_start, core_clr}, 0);
    xact(8'hA5, 5, 8'h3C, 4, 3);
    xact(8'hA5, 20, 8'h77, -1, 0);
    xact(8'h5A, 16, 8'hC3, 2, 1);
    xact(8'h81, 17, 8'h11, -1, 0);
    xact(8'h0F, 1, 8'hFF, 7, 2);
    for (int t = 0; t < 8; t++)
      xact(8'($urandom), $urandom_range(1, 20), 8'($urandom), $urandom_range(0, 7), $urandom_range(0, 3));
    chk("overrun_clear", overrun, 0);
    send_word(8'h96, -1, 0);
    din_q.push_back(8'h96);
    resp_q.push_back({1'b0, 8'h42});
    idle(2);
    put_bit(1'b1);
    chk("overrun_set", overrun, 1);
    chk("din_after_overrun", core_din, 8'h96);
    idle(1);
    core_done = 1;
    core_dout = 8'h42;
    idle(1);
    core_done = 0;
    wait_idle();
    xact(8'h3D, 3, 8'h99, -1, 0);
    chk("overrun_sticky", overrun, 1);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    rst = 1;
    idle(1);
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_outputs", {bit_out, bit_out_valid, core_start, core_clr, overrun}, 0);
    chk("midrst_core_din", core_din, 0);
    xact(8'hFF, 3, 8'hE1, -1, 0);
    idle(1000);
    chk("notimeout_busy", busy2, 1);
    chk("notimeout_clr", clr2_seen, 0);
    chk("notimeout_no_output", v2_seen, 0);
    chk("notimeout_din", core_din2, 8'hFF);
    chk("clr_pulses", clr_seen, exp_clr);
    chk("din_q_drained", din_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
